// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester and memory-side signal bundle for dmem_arbiter
interface dmem_arbiter_if;
  logic        a_req_i;
  logic        a_we_i;
  logic [31:0] a_addr_i;
  logic [31:0] a_data_i;
  logic        a_ack_o;
  logic        a_err_o;
  logic [31:0] a_data_o;
  logic        b_req_i;
  logic        b_we_i;
  logic [31:0] b_addr_i;
  logic [31:0] b_data_i;
  logic        b_ack_o;
  logic        b_err_o;
  logic [31:0] b_data_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic        mem_read_o;
  logic        mem_write_o;
  logic [31:0] mem_data_i;
  logic        busy_o;

  modport slave (
    input  a_req_i, a_we_i, a_addr_i, a_data_i,
    input  b_req_i, b_we_i, b_addr_i, b_data_i,
    input  mem_data_i,
    output a_ack_o, a_err_o, a_data_o,
    output b_ack_o, b_err_o, b_data_o,
    output mem_addr_o, mem_data_o, mem_read_o, mem_write_o, busy_o
  );

  modport master (
    output a_req_i, a_we_i, a_addr_i, a_data_i,
    output b_req_i, b_we_i, b_addr_i, b_data_i,
    output mem_data_i,
    input  a_ack_o, a_err_o, a_data_o,
    input  b_ack_o, b_err_o, b_data_o,
    input  mem_addr_o, mem_data_o, mem_read_o, mem_write_o, busy_o
  );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin arbiter in front of a single-port data memory
module dmem_arbiter #(
  parameter int unsigned MEM_LAT  = 1,
  parameter logic [31:0] ADDR_MAX = 32'd124
) (
  input logic           clk_i,
  input logic           rst_i,
  dmem_arbiter_if.slave bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  logic [1:0]  r_state;
  logic        r_grant;
  logic        r_last;
  logic        r_we;
  logic        r_err;
  logic [3:0]  r_cnt;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_a_data;
  logic [31:0] r_b_data;

  logic        w_arb_en;
  logic        w_a_elig;
  logic        w_b_elig;
  logic        w_grant_v;
  logic        w_win;
  logic        w_sel_we;
  logic [31:0] w_sel_addr;
  logic [31:0] w_sel_data;
  logic        w_sel_err;

  // Pick the next port: in RESP the port being acked still holds req and must be skipped
  always_comb begin
    w_arb_en   = (r_state == S_IDLE) || (r_state == S_RESP);
    w_a_elig   = bus.a_req_i && w_arb_en && !((r_state == S_RESP) && (r_grant == PORT_A));
    w_b_elig   = bus.b_req_i && w_arb_en && !((r_state == S_RESP) && (r_grant == PORT_B));
    w_grant_v  = w_a_elig || w_b_elig;
    w_win      = (w_a_elig && w_b_elig) ? ~r_last : w_b_elig;
    w_sel_we   = w_win ? bus.b_we_i   : bus.a_we_i;
    w_sel_addr = w_win ? bus.b_addr_i : bus.a_addr_i;
    w_sel_data = w_win ? bus.b_data_i : bus.a_data_i;
    w_sel_err  = (w_sel_addr[1:0] != 2'b00) || (w_sel_addr > ADDR_MAX);
  end

  // Transfer sequencing: grant, count out the access window, capture read data, ack
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_grant  <= PORT_A;
      r_last   <= PORT_B;
      r_we     <= 1'b0;
      r_err    <= 1'b0;
      r_cnt    <= 4'd0;
      r_addr   <= 32'd0;
      r_wdata  <= 32'd0;
      r_a_data <= 32'd0;
      r_b_data <= 32'd0;
    end else begin
      case (r_state)
        S_ACCESS: begin
          if (r_cnt == 4'd0) begin
            if (!r_we) begin
              if (r_grant == PORT_B) r_b_data <= bus.mem_data_i;
              else                   r_a_data <= bus.mem_data_i;
            end
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          if (w_grant_v) begin
            r_grant <= w_win;
            r_last  <= w_win;
            r_we    <= w_sel_we;
            r_err   <= w_sel_err;
            r_cnt   <= 4'(MEM_LAT - 1);
            if (w_sel_err) begin
              // rejected transfers never touch memory and report zero data
              r_state <= S_RESP;
              if (w_win == PORT_B) r_b_data <= 32'd0;
              else                 r_a_data <= 32'd0;
            end else begin
              // the memory-facing address/data only move for real accesses
              r_state <= S_ACCESS;
              r_addr  <= w_sel_addr;
              r_wdata <= w_sel_data;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.busy_o      = (r_state != S_IDLE);
  assign bus.mem_addr_o  = r_addr;
  assign bus.mem_data_o  = r_wdata;
  assign bus.mem_read_o  = (r_state == S_ACCESS) && !r_we;
  // a reset in the final access cycle must not let the write land
  assign bus.mem_write_o = (r_state == S_ACCESS) && r_we && (r_cnt == 4'd0) && !rst_i;

  assign bus.a_ack_o  = (r_state == S_RESP) && (r_grant == PORT_A);
  assign bus.b_ack_o  = (r_state == S_RESP) && (r_grant == PORT_B);
  assign bus.a_err_o  = bus.a_ack_o && r_err;
  assign bus.b_err_o  = bus.b_ack_o && r_err;
  assign bus.a_data_o = r_a_data;
  assign bus.b_data_o = r_b_data;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter at MEM_LAT 1, 2 and 3
module tb_dmem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  localparam int L_AACK = 0, L_BACK = 1, L_AERR = 2, L_BERR = 3, L_ADAT = 4, L_BDAT = 5;
  localparam int L_MRD = 6, L_MWR = 7, L_BUSY = 8, L_MADDR = 9, L_MEMW = 10;
  localparam int L_CNTA = 11, L_CNTB = 12, L_RDCNT = 13;

  logic        rst    [3];
  logic        a_req  [3];
  logic        a_we   [3];
  logic        b_req  [3];
  logic        b_we   [3];
  logic [31:0] a_addr [3];
  logic [31:0] a_wd   [3];
  logic [31:0] b_addr [3];
  logic [31:0] b_wd   [3];

  logic        w_aack [3];
  logic        w_aerr [3];
  logic        w_back [3];
  logic        w_berr [3];
  logic        w_mrd  [3];
  logic        w_mwr  [3];
  logic        w_busy [3];
  logic [31:0] w_adat [3];
  logic [31:0] w_bdat [3];
  logic [31:0] w_maddr[3];
  logic [31:0] w_mdata[3];

  logic [31:0] mem [3][32];
  int cyc = 0;

  for (genvar k = 0; k < 3; k++) begin : g_inst
    dmem_arbiter_if bus ();
    assign bus.a_req_i    = a_req[k];
    assign bus.a_we_i     = a_we[k];
    assign bus.a_addr_i   = a_addr[k];
    assign bus.a_data_i   = a_wd[k];
    assign bus.b_req_i    = b_req[k];
    assign bus.b_we_i     = b_we[k];
    assign bus.b_addr_i   = b_addr[k];
    assign bus.b_data_i   = b_wd[k];
    assign bus.mem_data_i = mem[k][bus.mem_addr_o[6:2]];
    assign w_aack[k]  = bus.a_ack_o;
    assign w_aerr[k]  = bus.a_err_o;
    assign w_adat[k]  = bus.a_data_o;
    assign w_back[k]  = bus.b_ack_o;
    assign w_berr[k]  = bus.b_err_o;
    assign w_bdat[k]  = bus.b_data_o;
    assign w_maddr[k] = bus.mem_addr_o;
    assign w_mdata[k] = bus.mem_data_o;
    assign w_mrd[k]   = bus.mem_read_o;
    assign w_mwr[k]   = bus.mem_write_o;
    assign w_busy[k]  = bus.busy_o;

    dmem_arbiter #(.MEM_LAT(k + 1), .ADDR_MAX(32'd124)) u_dut (
      .clk_i (clk),
      .rst_i (rst[k]),
      .bus   (bus)
    );
  end

  // transfer-level model: one record of the current transfer, timing by cycle arithmetic
  int          m_g   [3];
  int          m_ack [3];
  logic        m_port[3];
  logic        m_we  [3];
  logic        m_err [3];
  logic        m_last[3];
  logic [31:0] m_addr[3];
  logic [31:0] m_wd  [3];
  logic [31:0] m_da  [3];
  logic [31:0] m_db  [3];
  logic [31:0] m_ma  [3];
  logic [31:0] m_md  [3];
  logic [31:0] sh    [3][32];

  task automatic model_edge(input int k);
    int   lat;
    logic free, ea, eb, win, e;
    logic [31:0] ad;
    lat = k + 1;
    if (rst[k]) begin
      m_g[k] = -100; m_ack[k] = -100; m_last[k] = 1'b1;
      m_da[k] = 0; m_db[k] = 0; m_ma[k] = 0; m_md[k] = 0;
      return;
    end
    if (m_g[k] >= 0 && !m_err[k] && cyc == m_g[k] + lat) begin
      if (m_we[k]) sh[k][m_addr[k][6:2]] = m_wd[k];
      else if (m_port[k]) m_db[k] = sh[k][m_addr[k][6:2]];
      else m_da[k] = sh[k][m_addr[k][6:2]];
    end
    free = (cyc >= m_ack[k]);
    ea = a_req[k] && free && !(cyc == m_ack[k] && m_port[k] == 1'b0);
    eb = b_req[k] && free && !(cyc == m_ack[k] && m_port[k] == 1'b1);
    if (ea || eb) begin
      win = (ea && eb) ? !m_last[k] : eb;
      ad  = win ? b_addr[k] : a_addr[k];
      e   = (ad % 4 != 0) || (ad > 124);
      m_g[k] = cyc; m_port[k] = win; m_last[k] = win; m_err[k] = e;
      m_we[k] = win ? b_we[k] : a_we[k];
      m_addr[k] = ad;
      m_wd[k] = win ? b_wd[k] : a_wd[k];
      m_ack[k] = e ? cyc + 1 : cyc + lat + 1;
      if (e) begin
        if (win) m_db[k] = 0; else m_da[k] = 0;
      end else begin
        m_ma[k] = ad; m_md[k] = m_wd[k];
      end
    end
  endtask

  // memory behind each DUT, model update, then advance the cycle number
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (cyc == 0) begin
        for (int i = 0; i < 32; i++) begin
          mem[k][i] = (i == 0) ? 32'hCAFE_0000 : 32'd0;
          sh[k][i]  = mem[k][i];
        end
      end else if (w_mwr[k] === 1'b1) begin
        mem[k][w_maddr[k][6:2]] = w_mdata[k];
      end
      model_edge(k);
    end
    cyc++;
  end

  int n_pass = 0;
  int n_total = 0;
  int cnt_a0 = 0;
  int cnt_b0 = 0;
  int rd2 = 0;
  logic e_acc, e_rd, e_wr, e_aack, e_back, e_busy;

  int          q_cyc [$];
  int          q_k   [$];
  int          q_id  [$];
  int          q_idx [$];
  logic [31:0] q_exp [$];
  string       q_name[$];

  task automatic add_lit(input int c, input int k, input int id, input int idx,
                         input logic [31:0] ex, input string nm);
    q_cyc.push_back(c); q_k.push_back(k); q_id.push_back(id);
    q_idx.push_back(idx); q_exp.push_back(ex); q_name.push_back(nm);
  endtask

  function automatic logic [31:0] lit_act(input int k, input int id, input int idx);
    case (id)
      L_AACK:  return {31'd0, w_aack[k]};
      L_BACK:  return {31'd0, w_back[k]};
      L_AERR:  return {31'd0, w_aerr[k]};
      L_BERR:  return {31'd0, w_berr[k]};
      L_ADAT:  return w_adat[k];
      L_BDAT:  return w_bdat[k];
      L_MRD:   return {31'd0, w_mrd[k]};
      L_MWR:   return {31'd0, w_mwr[k]};
      L_BUSY:  return {31'd0, w_busy[k]};
      L_MADDR: return w_maddr[k];
      L_MEMW:  return mem[k][idx];
      L_CNTA:  return cnt_a0;
      L_CNTB:  return cnt_b0;
      default: return rd2;
    endcase
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] ex);
    n_total++;
    if (act === ex) n_pass++;
    else $display("FAIL %s inst%0d cycle %0d: got %h expected %h", nm, k, cyc, act, ex);
  endtask

  // single compare process: model every cycle, then any hand-computed literals due now
  always @(negedge clk) begin
    if (cyc >= 1) begin
      for (int k = 0; k < 3; k++) begin
        e_acc  = (m_g[k] >= 0) && !m_err[k] && (cyc > m_g[k]) && (cyc <= m_g[k] + k + 1);
        e_rd   = e_acc && !m_we[k];
        e_wr   = e_acc && m_we[k] && (cyc == m_g[k] + k + 1) && !rst[k];
        e_aack = (m_g[k] >= 0) && (cyc == m_ack[k]) && !m_port[k];
        e_back = (m_g[k] >= 0) && (cyc == m_ack[k]) && m_port[k];
        e_busy = (m_g[k] >= 0) && (cyc > m_g[k]) && (cyc <= m_ack[k]);
        chk("mem_read", k, {31'd0, w_mrd[k]}, {31'd0, e_rd});
        chk("mem_write", k, {31'd0, w_mwr[k]}, {31'd0, e_wr});
        chk("a_ack", k, {31'd0, w_aack[k]}, {31'd0, e_aack});
        chk("b_ack", k, {31'd0, w_back[k]}, {31'd0, e_back});
        chk("busy", k, {31'd0, w_busy[k]}, {31'd0, e_busy});
        chk("a_data", k, w_adat[k], m_da[k]);
        chk("b_data", k, w_bdat[k], m_db[k]);
        chk("mem_addr", k, w_maddr[k], m_ma[k]);
        chk("mem_data", k, w_mdata[k], m_md[k]);
        if (e_aack) chk("a_err", k, {31'd0, w_aerr[k]}, {31'd0, m_err[k]});
        if (e_back) chk("b_err", k, {31'd0, w_berr[k]}, {31'd0, m_err[k]});
      end
      if (cyc >= 32 && cyc <= 53) begin
        if (w_aack[0] === 1'b1) cnt_a0++;
        if (w_back[0] === 1'b1) cnt_b0++;
      end
      if (w_mrd[2] === 1'b1) rd2++;
      for (int i = 0; i < q_cyc.size(); i++)
        if (q_cyc[i] == cyc) chk(q_name[i], q_k[i], lit_act(q_k[i], q_id[i], q_idx[i]), q_exp[i]);
    end
  end

  task automatic at(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drv_a(input int k, input logic r, input logic we, input logic [31:0] ad, input logic [31:0] d);
    a_req[k] = r; a_we[k] = we; a_addr[k] = ad; a_wd[k] = d;
  endtask

  task automatic drv_b(input int k, input logic r, input logic we, input logic [31:0] ad, input logic [31:0] d);
    b_req[k] = r; b_we[k] = we; b_addr[k] = ad; b_wd[k] = d;
  endtask

  initial begin
    add_lit(1, 0, L_BUSY, 0, 0, "rst_busy");
    add_lit(1, 0, L_AACK, 0, 0, "rst_a_ack");
    add_lit(1, 0, L_ADAT, 0, 0, "rst_a_data");
    add_lit(1, 0, L_MADDR, 0, 0, "rst_mem_addr");
    add_lit(6, 0, L_AACK, 0, 1, "tie_a_ack");
    add_lit(7, 0, L_MWR, 0, 1, "tie_b_write");
    add_lit(8, 0, L_BACK, 0, 1, "tie_b_ack");
    add_lit(12, 0, L_ADAT, 0, 32'h11, "tie2_a_data");
    add_lit(14, 0, L_BDAT, 0, 32'hCAFE_0000, "tie2_b_data");
    add_lit(17, 0, L_MWR, 0, 0, "wr_not_early");
    add_lit(18, 0, L_MWR, 0, 1, "wr_strobe");
    add_lit(18, 0, L_MADDR, 0, 8, "wr_addr");
    add_lit(19, 0, L_AACK, 0, 1, "wr_ack");
    add_lit(19, 0, L_MWR, 0, 0, "wr_once");
    add_lit(23, 0, L_ADAT, 0, 32'hDEAD_BEEF, "rd_data");
    add_lit(23, 0, L_AERR, 0, 0, "rd_err");
    add_lit(26, 0, L_AACK, 0, 1, "mis_ack");
    add_lit(26, 0, L_AERR, 0, 1, "mis_err");
    add_lit(26, 0, L_ADAT, 0, 0, "mis_data");
    add_lit(26, 0, L_MRD, 0, 0, "mis_no_read");
    add_lit(29, 0, L_BACK, 0, 1, "oor_ack");
    add_lit(29, 0, L_BERR, 0, 1, "oor_err");
    add_lit(29, 0, L_MWR, 0, 0, "oor_no_write");
    add_lit(30, 0, L_MEMW, 0, 32'hCAFE_0000, "oor_mem");
    add_lit(54, 0, L_CNTA, 0, 5, "starve_a_acks");
    add_lit(54, 0, L_CNTB, 0, 5, "starve_b_acks");
    add_lit(6, 1, L_MWR, 0, 0, "rst_cancel_write");
    add_lit(7, 1, L_BUSY, 0, 0, "rst_mid_busy");
    add_lit(7, 1, L_AACK, 0, 0, "rst_mid_no_ack");
    add_lit(7, 1, L_MADDR, 0, 0, "rst_mid_addr");
    add_lit(8, 1, L_MEMW, 3, 0, "rst_mid_mem");
    add_lit(15, 1, L_MEMW, 3, 32'h55, "rearb_mem");
    add_lit(4, 2, L_MRD, 0, 0, "lat3_idle");
    add_lit(7, 2, L_MRD, 0, 1, "lat3_last_read");
    add_lit(8, 2, L_MRD, 0, 0, "lat3_read_end");
    add_lit(8, 2, L_AACK, 0, 1, "lat3_ack");
    add_lit(8, 2, L_ADAT, 0, 32'hCAFE_0000, "lat3_data");
    add_lit(9, 2, L_RDCNT, 0, 3, "lat3_read_cycles");

    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1;
      drv_a(k, 0, 0, 0, 0);
      drv_b(k, 0, 0, 0, 0);
    end
    at(2);
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;
    at(4);
    drv_a(0, 1, 0, 32'd0, 0);
    drv_b(0, 1, 1, 32'd4, 32'h11);
    drv_a(1, 1, 1, 32'd12, 32'h55);
    drv_a(2, 1, 0, 32'd0, 0);
    at(6);
    rst[1] = 1'b1;
    at(7);
    drv_a(0, 0, 0, 0, 0);
    rst[1] = 1'b0;
    drv_a(1, 0, 0, 0, 0);
    at(9);
    drv_b(0, 0, 0, 0, 0);
    drv_a(2, 0, 0, 0, 0);
    at(10);
    drv_a(0, 1, 0, 32'd4, 0);
    drv_b(0, 1, 0, 32'd0, 0);
    drv_a(1, 1, 1, 32'd12, 32'h55);
    at(13);
    drv_a(0, 0, 0, 0, 0);
    at(14);
    drv_a(1, 0, 0, 0, 0);
    at(15);
    drv_b(0, 0, 0, 0, 0);
    at(17);
    drv_a(0, 1, 1, 32'd8, 32'hDEAD_BEEF);
    at(20);
    drv_a(0, 0, 0, 0, 0);
    at(21);
    drv_a(0, 1, 0, 32'd8, 0);
    at(24);
    drv_a(0, 0, 0, 0, 0);
    at(25);
    drv_a(0, 1, 0, 32'd6, 0);
    at(27);
    drv_a(0, 0, 0, 0, 0);
    at(28);
    drv_b(0, 1, 1, 32'd128, 32'h77);
    at(30);
    drv_b(0, 0, 0, 0, 0);
    at(32);
    drv_a(0, 1, 0, 32'd8, 0);
    drv_b(0, 1, 0, 32'd4, 0);
    at(52);
    drv_a(0, 0, 0, 0, 0);
    drv_b(0, 0, 0, 0, 0);
    at(60);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
